// File: rtl/apb_arb_pkg.sv
// Shared state type and constants for the APB round-robin arbiter family.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

  localparam logic [31:0]  APB_ARB_ERR_DATA     = 32'hDEAD_BEEF;
  localparam int unsigned  APB_ARB_TIMEOUT_DFLT = 255;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational rotating-priority picker: first set request scanning ptr, ptr+1, ... mod NB_REQ.
module apb_rr_picker #(
  parameter int unsigned NB_REQ = 2
) (
  input  logic [NB_REQ-1:0]         i_req,
  input  logic [$clog2(NB_REQ)-1:0] i_ptr,
  output logic                      o_valid,
  output logic [$clog2(NB_REQ)-1:0] o_idx
);

  localparam int unsigned IW = $clog2(NB_REQ);

  always_comb begin : pick
    int unsigned c;
    o_valid = 1'b0;
    o_idx   = '0;
    c       = 0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      // ptr < NB_REQ, so a single subtraction is enough to wrap non-power-of-2 sizes
      c = 32'(i_ptr) + k;
      if (c >= NB_REQ) c = c - NB_REQ;
      if (!o_valid && i_req[c]) begin
        o_valid = 1'b1;
        o_idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one downstream APB port among NB_REQ upstream APB masters.
// Optional ACCESS watchdog is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NB_REQ         = 2,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = APB_ARB_TIMEOUT_DFLT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   s_paddr,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   s_pwdata,
  input  logic [NB_REQ-1:0]                  s_pwrite,
  input  logic [NB_REQ-1:0]                  s_psel,
  input  logic [NB_REQ-1:0]                  s_penable,
  output logic [NB_REQ*APB_DATA_WIDTH-1:0]   s_prdata,
  output logic [NB_REQ-1:0]                  s_pready,
  output logic [NB_REQ-1:0]                  s_pslverr,
  output logic [APB_ADDR_WIDTH-1:0]          m_paddr,
  output logic [APB_DATA_WIDTH-1:0]          m_pwdata,
  output logic                               m_pwrite,
  output logic                               m_psel,
  output logic                               m_penable,
  input  logic [APB_DATA_WIDTH-1:0]          m_prdata,
  input  logic                               m_pready,
  input  logic                               m_pslverr,
  output logic [$clog2(NB_REQ)-1:0]          grant_o,
  output logic                               busy_o,
  output logic                               timeout_o
);

  localparam int unsigned GW = $clog2(NB_REQ);
  localparam int unsigned AW = APB_ADDR_WIDTH;
  localparam int unsigned DW = APB_DATA_WIDTH;

  apb_arb_state_e r_state, w_state_nxt;
  logic [GW-1:0]  r_grant, w_grant_nxt;
  logic [GW-1:0]  r_ptr, w_ptr_nxt;
  logic [GW-1:0]  w_pick_idx, w_grant_inc;
  logic           w_pick_valid;
  logic           w_done, w_abort, w_to_hit;
  logic           w_unused;

  assign w_unused = ^{s_penable, (TIMEOUT_CYCLES == 0)};

  apb_rr_picker #(.NB_REQ(NB_REQ)) u_picker (
    .i_req   (s_psel),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_grant_inc = (r_grant == GW'(NB_REQ - 1)) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    m_psel      = 1'b0;
    m_penable   = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_idx;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        m_psel      = 1'b1;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        w_done    = m_pready;
        w_abort   = !m_pready && w_to_hit;
        if (w_done || w_abort) begin
          w_ptr_nxt   = w_grant_inc;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_paddr   = '0;
    m_pwdata  = '0;
    m_pwrite  = 1'b0;
    s_prdata  = '0;
    s_pready  = '0;
    s_pslverr = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (r_grant == GW'(i)) begin
        if (r_state != IDLE) begin
          m_paddr  = s_paddr[i*AW +: AW];
          m_pwdata = s_pwdata[i*DW +: DW];
          m_pwrite = s_pwrite[i];
        end
        // A requester that dropped psel mid-transfer gets no response; the bus still completes.
        if ((w_done || w_abort) && s_psel[i]) begin
          s_pready[i]           = 1'b1;
          s_pslverr[i]          = w_abort | m_pslverr;
          s_prdata[i*DW +: DW]  = w_abort ? DW'(APB_ARB_ERR_DATA) : m_prdata;
        end
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_to_cnt <= '0;
    end else if (r_state == ACCESS && !m_pready) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Counter holds the number of earlier stalled ACCESS cycles, so the limit hits on the last allowed one.
  assign w_to_hit  = (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_o = w_abort;
`else
  assign w_to_hit  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign busy_o  = (r_state != IDLE);
  assign grant_o = r_grant;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter (3 requesters): directed vector table, hand-written corner sequences,
// and a randomized run checked against a transaction-level model of the arbiter.
module tb_apb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     a_addr  [N];
  logic [31:0]     a_wdata [N];
  logic [N-1:0]    psel = '0, pwrite = '0, penable = '0;
  logic [N*AW-1:0] s_paddr;
  logic [N*DW-1:0] s_pwdata;
  logic [N*DW-1:0] s_prdata;
  logic [N-1:0]    s_pready, s_pslverr;
  logic [AW-1:0]   m_paddr;
  logic [DW-1:0]   m_pwdata;
  logic            m_pwrite, m_psel, m_penable;
  logic [DW-1:0]   m_prdata = '0;
  logic            m_pready = 1'b0, m_pslverr = 1'b0;
  logic [1:0]      grant_o;
  logic            busy_o, timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_paddr[i*AW +: AW]  = a_addr[i];
      s_pwdata[i*DW +: DW] = a_wdata[i];
    end
  end

  apb_rr_arbiter #(
    .NB_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(pwrite),
    .s_psel(psel), .s_penable(penable),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
    .m_psel(m_psel), .m_penable(m_penable),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ictl = {rst, m_pready, m_pslverr}; ectl = {m_psel, m_penable, busy_o}
  typedef struct {
    logic [2:0]  ictl;
    logic [2:0]  psel;
    logic [31:0] mrdata;
    logic [2:0]  ectl;
    logic [2:0]  espr;
    logic [2:0]  eslv;
    logic [1:0]  egrant;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] ictl, input logic [2:0] ps, input logic [31:0] rd,
                              input logic [2:0] ectl, input logic [2:0] espr, input logic [2:0] eslv,
                              input logic [1:0] eg);
    vec_t v;
    v.ictl = ictl; v.psel = ps; v.mrdata = rd; v.ectl = ectl;
    v.espr = espr; v.eslv = eslv; v.egrant = eg;
    return v;
  endfunction

  function automatic logic [255:0] bund(input logic sel, input logic en, input logic wr,
                                        input logic [31:0] ad, input logic [31:0] wd,
                                        input logic bz, input logic [1:0] gr, input logic to,
                                        input logic [2:0] pr, input logic [2:0] sl,
                                        input logic [95:0] rd);
    return 256'({sel, en, wr, ad, wd, bz, gr, to, pr, sl, rd});
  endfunction

  localparam logic [2:0] I_RST = 3'b100, I_RDY = 3'b010, I_WERR = 3'b001, I_RERR = 3'b011, I_NONE = 3'b000;
  localparam logic [2:0] E_IDLE = 3'b000, E_SETUP = 3'b101, E_ACC = 3'b111;

  vec_t        vecs[$];
  logic [95:0] exp_prd;
  logic [64:0] exp_mf;
  logic [1:0]  g;
  int          order[$];
  int          owner, age, ptr, last;
  logic        e_busy, e_acc, e_done, e_abort, found;
  logic [2:0]  e_spr, e_slv;
  logic        seen_to, stuck_ok;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_addr[0] = 32'h1A10_1000; a_wdata[0] = 32'h1234_5678;
    a_addr[1] = 32'h1A10_2004; a_wdata[1] = 32'h0BAD_F00D;
    a_addr[2] = 32'h1A10_3008; a_wdata[2] = 32'h55AA_55AA;
    pwrite = 3'b101;

    // Requester 0 alone, zero-wait write
    vecs.push_back(mk(I_RST,  3'b000, 32'h0, E_IDLE,  3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b001, 32'h0, E_IDLE,  3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b001, 32'h0, E_SETUP, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b001, 32'h0, E_ACC,   3'b001, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b000, 32'h0, E_IDLE,  3'b000, 3'b000, 2'd0));
    // Requesters 0 and 1 together after reset: 0,1,0,1
    vecs.push_back(mk(I_RST,  3'b000, 32'h0, E_IDLE,  3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_IDLE,  3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_SETUP, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_ACC,   3'b001, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_IDLE,  3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_SETUP, 3'b000, 3'b000, 2'd1));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_ACC,   3'b010, 3'b000, 2'd1));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_IDLE,  3'b000, 3'b000, 2'd1));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_SETUP, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_ACC,   3'b001, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_IDLE,  3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_SETUP, 3'b000, 3'b000, 2'd1));
    vecs.push_back(mk(I_RDY,  3'b011, 32'h0, E_ACC,   3'b010, 3'b000, 2'd1));
    vecs.push_back(mk(I_RDY,  3'b000, 32'h0, E_IDLE,  3'b000, 3'b000, 2'd1));
    // Requester 1 read, 3 wait states, slave error on completion
    vecs.push_back(mk(I_WERR, 3'b010, 32'hBAD0_BAD0, E_IDLE,  3'b000, 3'b000, 2'd1));
    vecs.push_back(mk(I_WERR, 3'b010, 32'hBAD0_BAD0, E_SETUP, 3'b000, 3'b000, 2'd1));
    vecs.push_back(mk(I_WERR, 3'b010, 32'hBAD0_BAD0, E_ACC,   3'b000, 3'b000, 2'd1));
    vecs.push_back(mk(I_WERR, 3'b010, 32'hBAD0_BAD0, E_ACC,   3'b000, 3'b000, 2'd1));
    vecs.push_back(mk(I_WERR, 3'b010, 32'hBAD0_BAD0, E_ACC,   3'b000, 3'b000, 2'd1));
    vecs.push_back(mk(I_RERR, 3'b010, 32'hCAFE_0001, E_ACC,   3'b010, 3'b010, 2'd1));
    vecs.push_back(mk(I_NONE, 3'b000, 32'h0,         E_IDLE,  3'b000, 3'b000, 2'd1));

    tick(); tick();
    for (int r = 0; r < vecs.size(); r++) begin
      tick();
      rst       = vecs[r].ictl[2];
      m_pready  = vecs[r].ictl[1];
      m_pslverr = vecs[r].ictl[0];
      m_prdata  = vecs[r].mrdata;
      psel      = vecs[r].psel;
      penable   = vecs[r].psel;
      #3;
      g = vecs[r].egrant;
      exp_prd = '0;
      for (int i = 0; i < N; i++)
        if (vecs[r].espr[i]) exp_prd[i*DW +: DW] = vecs[r].mrdata;
      exp_mf = vecs[r].ectl[2] ? {pwrite[g], a_addr[g], a_wdata[g]} : '0;
      check($sformatf("v%0d_msel", r),   m_psel,    vecs[r].ectl[2]);
      check($sformatf("v%0d_men", r),    m_penable, vecs[r].ectl[1]);
      check($sformatf("v%0d_busy", r),   busy_o,    vecs[r].ectl[0]);
      check($sformatf("v%0d_grant", r),  grant_o,   vecs[r].egrant);
      check($sformatf("v%0d_mfields", r), {m_pwrite, m_paddr, m_pwdata}, exp_mf);
      check($sformatf("v%0d_spready", r), s_pready,  vecs[r].espr);
      check($sformatf("v%0d_spslverr", r), s_pslverr, vecs[r].eslv);
      check($sformatf("v%0d_sprdata", r), s_prdata,  exp_prd);
      check($sformatf("v%0d_timeout", r), timeout_o, 1'b0);
    end

    // Reset during ACCESS of requester 2; pointer must restart at 0
    tick(); psel = 3'b100; m_pready = 1'b0;
    tick();
    tick(); #2;
    check("rstA_in_access", {m_psel, m_penable}, 2'b11);
    rst = 1'b1; #1;
    check("rstA_msel", m_psel, 1'b0);
    check("rstA_busy", busy_o, 1'b0);
    check("rstA_spready", s_pready, 3'b000);
    tick(); rst = 1'b0; psel = 3'b101;
    tick(); #3;
    check("rstA_grant", {m_psel, grant_o}, {1'b1, 2'd0});
    tick(); m_pready = 1'b1; m_prdata = 32'h0; m_pslverr = 1'b0; #3;
    check("rstA_done", s_pready, 3'b001);
    tick(); psel = 3'b000;

    // Slave never ready: requester 1 stalls, requester 2 queued behind it
    tick(); psel = 3'b110; m_pready = 1'b0;
    tick();
`ifdef APB_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      tick(); #3;
      if (k < TO) begin
        check($sformatf("to_wait%0d", k), {timeout_o, s_pready}, 4'b0000);
      end else begin
        check("to_spready", s_pready, 3'b010);
        check("to_pslverr", s_pslverr, 3'b010);
        check("to_prdata", s_prdata[63:32], 32'hDEAD_BEEF);
        check("to_pulse", timeout_o, 1'b1);
      end
    end
    tick(); #3;
    check("to_pulse_once", {timeout_o, m_psel}, 2'b00);
    tick(); #3;
    check("to_next_setup", {m_psel, grant_o}, {1'b1, 2'd2});
    tick(); m_pready = 1'b1; #3;
    check("to_next_done", s_pready, 3'b100);
    tick(); psel = 3'b000;
`else
    seen_to  = 1'b0;
    stuck_ok = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      tick(); #3;
      seen_to = seen_to | timeout_o;
      if (!(m_penable && busy_o && s_pready == 3'b000 && grant_o == 2'd1)) stuck_ok = 1'b0;
    end
    check("noto_stuck", stuck_ok, 1'b1);
    check("noto_no_pulse", seen_to, 1'b0);
    tick(); rst = 1'b1; psel = 3'b000;
    tick(); rst = 1'b0;
`endif

    // All three requesting continuously: strict 0,1,2 rotation
    tick(); rst = 1'b1; psel = 3'b000;
    tick(); rst = 1'b0; psel = 3'b111; m_pready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #3;
      for (int i = 0; i < N; i++) if (s_pready[i]) order.push_back(i);
      tick();
    end
    psel = 3'b000;
    check("fair_count", (order.size() >= 9), 1'b1);
    for (int k = 0; k < order.size() && k < 9; k++)
      check($sformatf("fair_order%0d", k), order[k], k % N);

    // Randomized run against a transaction-level model
    tick(); rst = 1'b1;
    tick();
    owner = -1; age = 0; ptr = 0; last = 0;
    for (int cyc = 0; cyc < 3000 && n_fail < 20; cyc++) begin
      tick();
      rst       = 1'b0;
      psel      = 3'($urandom_range(0, 7));
      penable   = psel;
      pwrite    = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        a_addr[i]  = $urandom();
        a_wdata[i] = $urandom();
      end
      m_pready  = ($urandom_range(0, 9) < 6);
      m_pslverr = 1'($urandom_range(0, 1));
      m_prdata  = $urandom();
      #3;
      e_busy  = (owner >= 0);
      e_acc   = e_busy && (age >= 2);
      e_done  = e_acc && m_pready;
      e_abort = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      e_abort = e_acc && !m_pready && (age - 1 == TO);
`endif
      e_spr = '0; e_slv = '0; exp_prd = '0;
      if ((e_done || e_abort) && psel[owner]) begin
        e_spr[owner] = 1'b1;
        e_slv[owner] = e_abort ? 1'b1 : m_pslverr;
        exp_prd[owner*DW +: DW] = e_abort ? 32'hDEAD_BEEF : m_prdata;
      end
      check($sformatf("rand%0d", cyc),
            bund(m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, busy_o, grant_o, timeout_o,
                 s_pready, s_pslverr, s_prdata),
            bund(e_busy, e_acc, e_busy ? pwrite[owner] : 1'b0,
                 e_busy ? a_addr[owner] : 32'h0, e_busy ? a_wdata[owner] : 32'h0,
                 e_busy, 2'(last), e_abort, e_spr, e_slv, exp_prd));
      if (e_done || e_abort) begin
        ptr   = (owner + 1) % N;
        owner = -1;
      end else if (e_busy) begin
        age++;
      end else begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && psel[(ptr + k) % N]) begin
            found = 1'b1;
            owner = (ptr + k) % N;
            last  = owner;
            age   = 1;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
